// File: rtl/filter_loader.sv
// rtl/filter_loader.sv - filter-weight stream loader with channel-interleaved write addressing
//
// Accepts one filter at a time over a valid/ready stream and writes each
// weight to the filter memory. The address is ((c*R + r)*S + s)*M + m, so
// the P filters a reader needs for one element position sit at consecutive
// addresses. The layer dimensions are checked when start is pulsed.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle pulse: latch M/C/R/S and begin a load
//   M, C, R, S          filters, channels, filter height, filter width
//   in_valid, in_data   weight stream from the host/DRAM side
//   in_ready            loader accepts a word this cycle
//   wr_en, wr_addr,
//   wr_data             registered filter memory write port
//   busy                load in progress
//   done                one-cycle pulse, coincident with the final write
//   err                 one-cycle pulse, rejected configuration
module filter_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [8:0]        M,
  input  logic [8:0]        C,
  input  logic [3:0]        R,
  input  logic [3:0]        S,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t state, state_nxt;

  logic [8:0] m_dim, c_dim;
  logic [3:0] r_dim, s_dim;
  logic [8:0] m_cnt, c_cnt;
  logic [3:0] r_cnt, s_cnt;

  // Full 26-bit product (9+9+4+4) so an oversized layer cannot wrap into range.
  logic [25:0] size;
  logic        bad_cfg;
  logic        accept_cfg;
  logic        xfer;
  logic        s_last, r_last, c_last, m_last;
  logic [25:0] addr_full;

  assign size       = 26'(M) * 26'(C) * 26'(R) * 26'(S);
  assign bad_cfg    = (M == 9'd0) || (C == 9'd0) || (R == 4'd0) || (S == 4'd0) ||
                      (size > 26'(DEPTH));
  assign accept_cfg = (state == IDLE) && start && !bad_cfg;
  assign xfer       = (state == LOAD) && in_valid;

  assign s_last = (s_cnt == s_dim - 4'd1);
  assign r_last = (r_cnt == r_dim - 4'd1);
  assign c_last = (c_cnt == c_dim - 9'd1);
  assign m_last = (m_cnt == m_dim - 9'd1);

  // Channel-interleaved layout; a valid config keeps this below DEPTH.
  assign addr_full = ((26'(c_cnt) * 26'(r_dim) + 26'(r_cnt)) * 26'(s_dim) + 26'(s_cnt))
                     * 26'(m_dim) + 26'(m_cnt);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept_cfg) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer && s_last && r_last && c_last && m_last) state_nxt = DONE;
      end
      DONE: begin
        // The last word's write is on the port this cycle.
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      err     <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      m_dim   <= '0;
      c_dim   <= '0;
      r_dim   <= '0;
      s_dim   <= '0;
      m_cnt   <= '0;
      c_cnt   <= '0;
      r_cnt   <= '0;
      s_cnt   <= '0;
    end else begin
      state <= state_nxt;
      err   <= (state == IDLE) && start && bad_cfg;
      wr_en <= xfer;
      if (xfer) begin
        wr_addr <= addr_full[ADDR_W-1:0];
        wr_data <= in_data;
      end

      if (accept_cfg) begin
        m_dim <= M;
        c_dim <= C;
        r_dim <= R;
        s_dim <= S;
        m_cnt <= '0;
        c_cnt <= '0;
        r_cnt <= '0;
        s_cnt <= '0;
      end else if (xfer) begin
        // Stream order: s fastest, then r, c, m.
        if (!s_last) begin
          s_cnt <= s_cnt + 4'd1;
        end else begin
          s_cnt <= '0;
          if (!r_last) begin
            r_cnt <= r_cnt + 4'd1;
          end else begin
            r_cnt <= '0;
            if (!c_last) begin
              c_cnt <= c_cnt + 9'd1;
            end else begin
              c_cnt <= '0;
              m_cnt <= m_cnt + 9'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_filter_loader.sv
// tb/tb_filter_loader.sv - self-checking bench for filter_loader
module tb_filter_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  dm, dc;
  logic [3:0]  dr, ds;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  filter_loader #(.DATA_W(16), .ADDR_W(10), .DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .start(start),
    .M(dm), .C(dc), .R(dr), .S(ds),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int addr;
    int data;
  } wr_t;

  typedef struct {
    int m, c, r, s;
    int mode;        // 0 continuous, 1 toggling 1/0, 2 random valid
    int abort_at;    // assert rst after this many accepted words (0 = never)
    bit restart;     // pulse start again while loading
    bit exp_err;
    int exp_writes;
    int exp_done;
  } vec_t;

  wr_t exp_q[$];
  int  stream[$];
  wr_t mon_e;
  bit  mon_en = 1'b0;
  int  wr_cnt, done_cnt, err_cnt, rdy_cnt, busy_cnt;

  // Write-port scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (in_ready) rdy_cnt++;
      if (busy) busy_cnt++;
      if (err) err_cnt++;
      if (wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", int'(wr_addr), mon_e.addr);
          chk("wr_data", int'(wr_data), mon_e.data);
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_on_last_write", {30'd0, wr_en, (exp_q.size() == 0)}, 3);
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_wr_en"},    int'(wr_en),    0);
    chk({tag, "_wr_addr"},  int'(wr_addr),  0);
    chk({tag, "_wr_data"},  int'(wr_data),  0);
    chk({tag, "_busy"},     int'(busy),     0);
    chk({tag, "_done"},     int'(done),     0);
    chk({tag, "_err"},      int'(err),      0);
  endtask

  // Entered and left at posedge+#1.
  task automatic run_vec(input vec_t v);
    int  n, idx, cyc, limit;
    bit  aborted, stuck, vld;
    n = v.m * v.c * v.r * v.s;
    wr_cnt = 0; done_cnt = 0; err_cnt = 0; rdy_cnt = 0; busy_cnt = 0;
    exp_q.delete();
    stream.delete();

    // Reference: walk the filter in stream order and place each word.
    if (!v.exp_err) begin
      for (int m = 0; m < v.m; m++)
        for (int c = 0; c < v.c; c++)
          for (int r = 0; r < v.r; r++)
            for (int s = 0; s < v.s; s++) begin
              int d;
              d = int'($urandom_range(0, 65535));
              stream.push_back(d);
              exp_q.push_back('{addr: ((c * v.r + r) * v.s + s) * v.m + m, data: d});
            end
    end

    mon_en = 1'b1;
    dm = v.m[8:0]; dc = v.c[8:0]; dr = v.r[3:0]; ds = v.s[3:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    if (v.exp_err) begin
      repeat (3) @(posedge clk);
      #1;
      chk("err_pulse_count", err_cnt, 1);
      chk("err_no_write", wr_cnt, 0);
      chk("err_no_ready", rdy_cnt, 0);
      chk("err_no_busy", busy_cnt, 0);
    end else begin
      idx = 0; cyc = 0; aborted = 0; stuck = 0;
      limit = 4 * n + 20;
      while (idx < n && cyc < limit && !aborted && !stuck) begin
        case (v.mode)
          0:       vld = 1'b1;
          1:       vld = (cyc % 2 == 0);
          default: vld = 1'($urandom_range(0, 1));
        endcase
        in_valid = vld;
        in_data  = stream[idx][15:0];
        if (v.restart && cyc == 3) begin
          start = 1'b1;
          dm = 9'd1; dc = 9'd1; dr = 4'd1; ds = 4'd1;
        end
        if (!in_ready) begin
          chk("in_ready_during_load", 0, 1);
          stuck = 1;
        end else begin
          @(posedge clk); #1;
          start    = 1'b0;
          in_valid = 1'b0;
          chk("wr_en_follows_transfer", int'(wr_en), int'(vld));
          if (vld) idx++;
          cyc++;
          if (v.abort_at > 0 && idx == v.abort_at) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check_idle_outputs("after_abort");
            aborted = 1;
          end
        end
      end
      if (!aborted) begin
        chk("accept_all_words", idx, n);
        chk("in_ready_cycles", rdy_cnt, cyc);
        repeat (3) @(posedge clk);
        #1;
        chk("end_in_ready", int'(in_ready), 0);
        chk("end_busy", int'(busy), 0);
        chk("leftover_writes", exp_q.size(), 0);
      end
      chk("write_count", wr_cnt, v.exp_writes);
      chk("done_count", done_cnt, v.exp_done);
      chk("no_err", err_cnt, 0);
    end
    mon_en = 1'b0;
  endtask

  vec_t tbl[10];

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{m:2,   c:1, r:2, s:2, mode:0, abort_at:0,  restart:0, exp_err:0, exp_writes:8,    exp_done:1};
    tbl[1] = '{m:1,   c:1, r:1, s:1, mode:0, abort_at:0,  restart:0, exp_err:0, exp_writes:1,    exp_done:1};
    tbl[2] = '{m:4,   c:4, r:8, s:8, mode:1, abort_at:0,  restart:0, exp_err:0, exp_writes:1024, exp_done:1};
    tbl[3] = '{m:16,  c:8, r:3, s:3, mode:0, abort_at:0,  restart:0, exp_err:1, exp_writes:0,    exp_done:0};
    tbl[4] = '{m:16,  c:8, r:0, s:3, mode:0, abort_at:0,  restart:0, exp_err:1, exp_writes:0,    exp_done:0};
    tbl[5] = '{m:3,   c:2, r:3, s:3, mode:0, abort_at:10, restart:0, exp_err:0, exp_writes:10,   exp_done:0};
    tbl[6] = '{m:1,   c:1, r:2, s:2, mode:0, abort_at:0,  restart:0, exp_err:0, exp_writes:4,    exp_done:1};
    tbl[7] = '{m:2,   c:1, r:2, s:2, mode:0, abort_at:0,  restart:1, exp_err:0, exp_writes:8,    exp_done:1};
    tbl[8] = '{m:0,   c:3, r:2, s:2, mode:0, abort_at:0,  restart:0, exp_err:1, exp_writes:0,    exp_done:0};
    tbl[9] = '{m:511, c:2, r:1, s:1, mode:2, abort_at:0,  restart:0, exp_err:0, exp_writes:1022, exp_done:1};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    dm = '0; dc = '0; dr = '0; ds = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_vec(tbl[i]);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 8; i++) begin
      vec_t v;
      int   p;
      v.m = int'($urandom_range(0, 40));
      v.c = int'($urandom_range(1, 6));
      v.r = int'($urandom_range(1, 5));
      v.s = int'($urandom_range(0, 5));
      v.mode = 2; v.abort_at = 0; v.restart = 0;
      p = v.m * v.c * v.r * v.s;
      v.exp_err    = (p == 0) || (p > 1024);
      v.exp_writes = v.exp_err ? 0 : p;
      v.exp_done   = v.exp_err ? 0 : 1;
      run_vec(v);
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
